// File: rtl/scr1_ahb_mem_arb.sv
// 2:1 AHB-Lite arbiter: imem and dmem share one single-ported memory slave.
// Each master's address phase is parked in a slot; slots are issued one at a time.
module scr1_ahb_mem_arb #(
  parameter int unsigned AHB_W  = 32,
  parameter bit          ARB_RR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  // imem master port
  input  logic [1:0]       imem_htrans,
  input  logic [AHB_W-1:0] imem_haddr,
  input  logic [2:0]       imem_hsize,
  output logic             imem_hready,
  output logic [AHB_W-1:0] imem_hrdata,
  output logic             imem_hresp,
  // dmem master port
  input  logic [1:0]       dmem_htrans,
  input  logic [AHB_W-1:0] dmem_haddr,
  input  logic [2:0]       dmem_hsize,
  input  logic             dmem_hwrite,
  input  logic [AHB_W-1:0] dmem_hwdata,
  output logic             dmem_hready,
  output logic [AHB_W-1:0] dmem_hrdata,
  output logic             dmem_hresp,
  // memory slave port
  output logic [1:0]       mem_htrans,
  output logic [AHB_W-1:0] mem_haddr,
  output logic [2:0]       mem_hsize,
  output logic             mem_hwrite,
  output logic [AHB_W-1:0] mem_hwdata,
  input  logic             mem_hready,
  input  logic [AHB_W-1:0] mem_hrdata,
  input  logic             mem_hresp
);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  typedef enum logic [1:0] {StIdle, StDataI, StDataD} state_e;

  state_e           state_q, state_d;
  logic             i_vld_q, i_vld_d;
  logic [AHB_W-1:0] i_addr_q, i_addr_d;
  logic [2:0]       i_size_q, i_size_d;
  logic             d_vld_q, d_vld_d;
  logic [AHB_W-1:0] d_addr_q, d_addr_d;
  logic [2:0]       d_size_q, d_size_d;
  logic             d_write_q, d_write_d;
  logic             last_d_q, last_d_d;  // 1: last grant went to dmem

  logic i_req, d_req, i_done, d_done, grant_d;

  // Master-side handshake and slot capture
  always_comb begin
    i_req  = (imem_htrans == HtransNonseq) || (imem_htrans == HtransSeq);
    d_req  = (dmem_htrans == HtransNonseq) || (dmem_htrans == HtransSeq);
    i_done = (state_q == StDataI) && mem_hready;
    d_done = (state_q == StDataD) && mem_hready;

    imem_hready = !i_vld_q || i_done;
    dmem_hready = !d_vld_q || d_done;
    imem_hresp  = (state_q == StDataI) ? mem_hresp : 1'b0;
    dmem_hresp  = (state_q == StDataD) ? mem_hresp : 1'b0;
    imem_hrdata = mem_hrdata;
    dmem_hrdata = mem_hrdata;

    i_vld_d  = i_vld_q;
    i_addr_d = i_addr_q;
    i_size_d = i_size_q;
    if (i_done) i_vld_d = 1'b0;
    // A new request in the completion cycle overrides the clear
    if (i_req && imem_hready) begin
      i_vld_d  = 1'b1;
      i_addr_d = imem_haddr;
      i_size_d = imem_hsize;
    end

    d_vld_d   = d_vld_q;
    d_addr_d  = d_addr_q;
    d_size_d  = d_size_q;
    d_write_d = d_write_q;
    if (d_done) d_vld_d = 1'b0;
    if (d_req && dmem_hready) begin
      d_vld_d   = 1'b1;
      d_addr_d  = dmem_haddr;
      d_size_d  = dmem_hsize;
      d_write_d = dmem_hwrite;
    end
  end

  // Slave-side sequencing
  always_comb begin
    grant_d    = d_vld_q && (!i_vld_q || !ARB_RR || !last_d_q);
    state_d    = state_q;
    last_d_d   = last_d_q;
    mem_htrans = HtransIdle;
    mem_haddr  = '0;
    mem_hsize  = '0;
    mem_hwrite = 1'b0;
    mem_hwdata = '0;
    case (state_q)
      StIdle: begin
        if (i_vld_q || d_vld_q) begin
          mem_htrans = HtransNonseq;
          last_d_d   = grant_d;
          if (grant_d) begin
            mem_haddr  = d_addr_q;
            mem_hsize  = d_size_q;
            mem_hwrite = d_write_q;
            state_d    = StDataD;
          end else begin
            mem_haddr = i_addr_q;
            mem_hsize = i_size_q;
            state_d   = StDataI;
          end
        end
      end
      StDataI: begin
        mem_haddr = i_addr_q;
        mem_hsize = i_size_q;
        if (mem_hready) state_d = StIdle;
      end
      StDataD: begin
        mem_haddr  = d_addr_q;
        mem_hsize  = d_size_q;
        mem_hwrite = d_write_q;
        mem_hwdata = dmem_hwdata;
        if (mem_hready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      i_vld_q   <= 1'b0;
      i_addr_q  <= '0;
      i_size_q  <= '0;
      d_vld_q   <= 1'b0;
      d_addr_q  <= '0;
      d_size_q  <= '0;
      d_write_q <= 1'b0;
      last_d_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_vld_q   <= i_vld_d;
      i_addr_q  <= i_addr_d;
      i_size_q  <= i_size_d;
      d_vld_q   <= d_vld_d;
      d_addr_q  <= d_addr_d;
      d_size_q  <= d_size_d;
      d_write_q <= d_write_d;
      last_d_q  <= last_d_d;
    end
  end

endmodule

// File: tb/tb_scr1_ahb_mem_arb.sv
// Bench for scr1_ahb_mem_arb: round-robin and fixed-priority instances, master/slave models
// and an issue-order scoreboard on the memory port.
module tb_scr1_ahb_mem_arb;
  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] addr;
    logic [2:0]   size;
    logic         write;
    logic [W-1:0] wdata;
    logic         err;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   imem_htrans, dmem_htrans;
  logic [W-1:0] imem_haddr, dmem_haddr, dmem_hwdata;
  logic [2:0]   imem_hsize, dmem_hsize;
  logic         dmem_hwrite, mem_hready, mem_hresp, sel_fp;

  logic         rr_imem_hready, rr_imem_hresp, rr_dmem_hready, rr_dmem_hresp, rr_mem_hwrite;
  logic [W-1:0] rr_imem_hrdata, rr_dmem_hrdata, rr_mem_haddr, rr_mem_hwdata, rr_mem_hrdata;
  logic [1:0]   rr_mem_htrans;
  logic [2:0]   rr_mem_hsize;
  logic         fp_imem_hready, fp_imem_hresp, fp_dmem_hready, fp_dmem_hresp, fp_mem_hwrite;
  logic [W-1:0] fp_imem_hrdata, fp_dmem_hrdata, fp_mem_haddr, fp_mem_hwdata, fp_mem_hrdata;
  logic [1:0]   fp_mem_htrans;
  logic [2:0]   fp_mem_hsize;

  scr1_ahb_mem_arb #(.AHB_W(W), .ARB_RR(1'b1)) u_dut_rr (
    .clk(clk), .rst_n(rst_n),
    .imem_htrans(imem_htrans), .imem_haddr(imem_haddr), .imem_hsize(imem_hsize),
    .imem_hready(rr_imem_hready), .imem_hrdata(rr_imem_hrdata), .imem_hresp(rr_imem_hresp),
    .dmem_htrans(dmem_htrans), .dmem_haddr(dmem_haddr), .dmem_hsize(dmem_hsize),
    .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
    .dmem_hready(rr_dmem_hready), .dmem_hrdata(rr_dmem_hrdata), .dmem_hresp(rr_dmem_hresp),
    .mem_htrans(rr_mem_htrans), .mem_haddr(rr_mem_haddr), .mem_hsize(rr_mem_hsize),
    .mem_hwrite(rr_mem_hwrite), .mem_hwdata(rr_mem_hwdata),
    .mem_hready(mem_hready), .mem_hrdata(rr_mem_hrdata), .mem_hresp(mem_hresp)
  );

  scr1_ahb_mem_arb #(.AHB_W(W), .ARB_RR(1'b0)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .imem_htrans(imem_htrans), .imem_haddr(imem_haddr), .imem_hsize(imem_hsize),
    .imem_hready(fp_imem_hready), .imem_hrdata(fp_imem_hrdata), .imem_hresp(fp_imem_hresp),
    .dmem_htrans(dmem_htrans), .dmem_haddr(dmem_haddr), .dmem_hsize(dmem_hsize),
    .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
    .dmem_hready(fp_dmem_hready), .dmem_hrdata(fp_dmem_hrdata), .dmem_hresp(fp_dmem_hresp),
    .mem_htrans(fp_mem_htrans), .mem_haddr(fp_mem_haddr), .mem_hsize(fp_mem_hsize),
    .mem_hwrite(fp_mem_hwrite), .mem_hwdata(fp_mem_hwdata),
    .mem_hready(mem_hready), .mem_hrdata(fp_mem_hrdata), .mem_hresp(mem_hresp)
  );

  // Slave models: read data is the inverted address of the last accepted address phase
  logic [W-1:0] rr_slv_addr, fp_slv_addr;
  always @(posedge clk) if (rr_mem_htrans == 2'b10 && mem_hready) rr_slv_addr <= rr_mem_haddr;
  always @(posedge clk) if (fp_mem_htrans == 2'b10 && mem_hready) fp_slv_addr <= fp_mem_haddr;
  assign rr_mem_hrdata = ~rr_slv_addr;
  assign fp_mem_hrdata = ~fp_slv_addr;

  logic         imem_hready_s, imem_hresp_s, dmem_hready_s, dmem_hresp_s, mem_hwrite_s;
  logic [W-1:0] imem_hrdata_s, dmem_hrdata_s, mem_haddr_s, mem_hwdata_s;
  logic [1:0]   mem_htrans_s;
  logic [2:0]   mem_hsize_s;
  assign imem_hready_s = sel_fp ? fp_imem_hready : rr_imem_hready;
  assign imem_hresp_s  = sel_fp ? fp_imem_hresp  : rr_imem_hresp;
  assign imem_hrdata_s = sel_fp ? fp_imem_hrdata : rr_imem_hrdata;
  assign dmem_hready_s = sel_fp ? fp_dmem_hready : rr_dmem_hready;
  assign dmem_hresp_s  = sel_fp ? fp_dmem_hresp  : rr_dmem_hresp;
  assign dmem_hrdata_s = sel_fp ? fp_dmem_hrdata : rr_dmem_hrdata;
  assign mem_htrans_s  = sel_fp ? fp_mem_htrans  : rr_mem_htrans;
  assign mem_haddr_s   = sel_fp ? fp_mem_haddr   : rr_mem_haddr;
  assign mem_hsize_s   = sel_fp ? fp_mem_hsize   : rr_mem_hsize;
  assign mem_hwrite_s  = sel_fp ? fp_mem_hwrite  : rr_mem_hwrite;
  assign mem_hwdata_s  = sel_fp ? fp_mem_hwdata  : rr_mem_hwdata;

  req_t i_q[$], d_q[$], exp_q[$];
  req_t i_dp, d_dp, mon_cur, r;
  logic i_dp_vld = 1'b0, d_dp_vld = 1'b0, mon_dp = 1'b0;
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic req_t mk(input logic [W-1:0] a, input logic [2:0] sz, input logic wr,
                              input logic [W-1:0] wd, input logic err);
    req_t q;
    q.addr = a; q.size = sz; q.write = wr; q.wdata = wd; q.err = err;
    return q;
  endfunction

  // imem master model
  initial begin
    imem_htrans = 2'b00; imem_haddr = '0; imem_hsize = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) i_dp_vld = 1'b0;
      else if (imem_hready_s === 1'b1) begin
        if (i_dp_vld) begin
          chk("imem_hresp_done", W'(imem_hresp_s), W'(i_dp.err));
          if (!i_dp.err) chk("imem_hrdata", imem_hrdata_s, ~i_dp.addr);
        end
        i_dp_vld = (imem_htrans == 2'b10);
        if (i_dp_vld) i_dp = i_q.pop_front();
      end
      @(posedge clk); #2;
      if (i_q.size() != 0) begin
        imem_htrans = 2'b10; imem_haddr = i_q[0].addr; imem_hsize = i_q[0].size;
      end else begin
        imem_htrans = 2'b00; imem_haddr = '0; imem_hsize = '0;
      end
    end
  end

  // dmem master model
  initial begin
    dmem_htrans = 2'b00; dmem_haddr = '0; dmem_hsize = '0; dmem_hwrite = 1'b0;
    dmem_hwdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) d_dp_vld = 1'b0;
      else if (dmem_hready_s === 1'b1) begin
        if (d_dp_vld) begin
          chk("dmem_hresp_done", W'(dmem_hresp_s), W'(d_dp.err));
          if (!d_dp.write && !d_dp.err) chk("dmem_hrdata", dmem_hrdata_s, ~d_dp.addr);
        end
        d_dp_vld = (dmem_htrans == 2'b10);
        if (d_dp_vld) d_dp = d_q.pop_front();
      end
      @(posedge clk); #2;
      dmem_hwdata = (d_dp_vld && d_dp.write) ? d_dp.wdata : '0;
      if (d_q.size() != 0) begin
        dmem_htrans = 2'b10; dmem_haddr = d_q[0].addr; dmem_hsize = d_q[0].size;
        dmem_hwrite = d_q[0].write;
      end else begin
        dmem_htrans = 2'b00; dmem_haddr = '0; dmem_hsize = '0; dmem_hwrite = 1'b0;
      end
    end
  end

  // Memory-port monitor: issue order, fields and write data against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) mon_dp = 1'b0;
      else begin
        if (mon_dp) begin
          chk("mem_hwdata", mem_hwdata_s, mon_cur.write ? mon_cur.wdata : '0);
          if (mem_hready) mon_dp = 1'b0;
        end
        if (mem_htrans_s == 2'b10) begin
          if (exp_q.size() == 0) chk("issue_unexpected", W'(exp_q.size()), W'(1));
          else begin
            mon_cur = exp_q.pop_front();
            chk("issue_haddr", mem_haddr_s, mon_cur.addr);
            chk("issue_hsize", W'(mem_hsize_s), W'(mon_cur.size));
            chk("issue_hwrite", W'(mem_hwrite_s), W'(mon_cur.write));
            mon_dp = 1'b1;
          end
        end else chk("mem_htrans_idle", W'(mem_htrans_s), W'(0));
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((i_q.size() + d_q.size() + exp_q.size()) != 0 || i_dp_vld || d_dp_vld || mon_dp) begin
      if (n == 100) break;
      @(negedge clk);
      n++;
    end
    chk(tag, W'(n < 100), W'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_hready = 1'b1; mem_hresp = 1'b0; sel_fp = 1'b0;
    @(negedge clk);
    chk("rst_imem_hready", W'(imem_hready_s), W'(1));
    chk("rst_dmem_hready", W'(dmem_hready_s), W'(1));
    chk("rst_imem_hresp", W'(imem_hresp_s), W'(0));
    chk("rst_dmem_hresp", W'(dmem_hresp_s), W'(0));
    chk("rst_mem_htrans", W'(mem_htrans_s), W'(0));
    chk("rst_mem_haddr", mem_haddr_s, '0);
    chk("rst_mem_hsize", W'(mem_hsize_s), W'(0));
    chk("rst_mem_hwrite", W'(mem_hwrite_s), W'(0));
    chk("rst_mem_hwdata", mem_hwdata_s, '0);
    nxt(); rst_n = 1'b1;

    // Single imem read, zero-wait slave
    nxt();
    r = mk(32'h100, 3'd2, 1'b0, '0, 1'b0); i_q.push_back(r); exp_q.push_back(r);
    nxt(); @(negedge clk);
    chk("t1_c1_htrans", W'(mem_htrans_s), W'(2'b10));
    chk("t1_c1_haddr", mem_haddr_s, 32'h100);
    chk("t1_c1_hwrite", W'(mem_hwrite_s), W'(0));
    nxt(); @(negedge clk);
    chk("t1_c2_hready", W'(imem_hready_s), W'(1));
    chk("t1_c2_hrdata", imem_hrdata_s, ~32'h100);
    drain("t1_drain");

    // Same-cycle ties with both masters streaming: dmem first, then alternation
    nxt();
    for (int k = 0; k < 3; k++) begin
      d_q.push_back(mk(32'h300 + 32'(4 * k), 3'd2, 1'b1, 32'hDEADBEEF + 32'(k), 1'b0));
      i_q.push_back(mk(32'h200 + 32'(4 * k), 3'd2, 1'b0, '0, 1'b0));
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(d_q[k]);
      exp_q.push_back(i_q[k]);
    end
    nxt(); @(negedge clk);
    chk("t2_c1_haddr", mem_haddr_s, 32'h300);
    chk("t2_c1_hwrite", W'(mem_hwrite_s), W'(1));
    nxt(); @(negedge clk);
    chk("t2_c2_hwdata", mem_hwdata_s, 32'hDEADBEEF);
    chk("t2_c2_dmem_hready", W'(dmem_hready_s), W'(1));
    chk("t2_c2_imem_hready", W'(imem_hready_s), W'(0));
    nxt(); @(negedge clk);
    chk("t2_c3_htrans", W'(mem_htrans_s), W'(2'b10));
    chk("t2_c3_haddr", mem_haddr_s, 32'h200);
    drain("t2_drain");

    // Three wait states on a dmem read with an imem request parked behind it
    nxt();
    r = mk(32'h400, 3'd1, 1'b0, '0, 1'b0); d_q.push_back(r); exp_q.push_back(r);
    nxt();
    r = mk(32'h180, 3'd2, 1'b0, '0, 1'b0); i_q.push_back(r); exp_q.push_back(r);
    @(negedge clk);
    chk("t4_c1_dmem_hready", W'(dmem_hready_s), W'(0));
    for (int c = 2; c < 5; c++) begin
      nxt(); mem_hready = 1'b0; @(negedge clk);
      chk("t4_wait_dmem_hready", W'(dmem_hready_s), W'(0));
      chk("t4_wait_imem_hready", W'(imem_hready_s), W'(0));
    end
    nxt(); mem_hready = 1'b1; @(negedge clk);
    chk("t4_c5_dmem_hready", W'(dmem_hready_s), W'(1));
    chk("t4_c5_imem_hready", W'(imem_hready_s), W'(0));
    drain("t4_drain");

    // Two-cycle ERROR on an imem fetch
    nxt();
    r = mk(32'h1C0, 3'd2, 1'b0, '0, 1'b1); i_q.push_back(r); exp_q.push_back(r);
    nxt();
    r = mk(32'h500, 3'd2, 1'b0, '0, 1'b0); d_q.push_back(r); exp_q.push_back(r);
    nxt(); mem_hready = 1'b0; mem_hresp = 1'b1; @(negedge clk);
    chk("t5_e1_imem_hresp", W'(imem_hresp_s), W'(1));
    chk("t5_e1_imem_hready", W'(imem_hready_s), W'(0));
    chk("t5_e1_dmem_hresp", W'(dmem_hresp_s), W'(0));
    nxt(); mem_hready = 1'b1; @(negedge clk);
    chk("t5_e2_imem_hresp", W'(imem_hresp_s), W'(1));
    chk("t5_e2_imem_hready", W'(imem_hready_s), W'(1));
    chk("t5_e2_dmem_hresp", W'(dmem_hresp_s), W'(0));
    nxt(); mem_hresp = 1'b0;
    drain("t5_drain");

    // Reset in the middle of a waited dmem data phase
    nxt();
    r = mk(32'h600, 3'd2, 1'b0, '0, 1'b0); d_q.push_back(r); exp_q.push_back(r);
    nxt();
    nxt(); mem_hready = 1'b0;
    nxt(); rst_n = 1'b0;
    nxt(); rst_n = 1'b1; mem_hready = 1'b1; @(negedge clk);
    chk("t6_imem_hready", W'(imem_hready_s), W'(1));
    chk("t6_dmem_hready", W'(dmem_hready_s), W'(1));
    chk("t6_mem_htrans", W'(mem_htrans_s), W'(0));
    nxt(); @(negedge clk);
    chk("t6_no_reissue", W'(mem_htrans_s), W'(0));
    drain("t6_drain");

    // Fixed priority: 8 back-to-back dmem reads starve a pending imem read
    nxt(); rst_n = 1'b0; sel_fp = 1'b1;
    nxt(); nxt(); rst_n = 1'b1;
    nxt();
    for (int k = 0; k < 8; k++) begin
      r = mk(32'h700 + 32'(4 * k), 3'(k % 3), 1'b0, '0, 1'b0);
      d_q.push_back(r); exp_q.push_back(r);
    end
    r = mk(32'h1F0, 3'd2, 1'b0, '0, 1'b0); i_q.push_back(r); exp_q.push_back(r);
    for (int c = 1; c < 18; c++) begin
      nxt(); @(negedge clk);
      chk("t3_imem_starved", W'(imem_hready_s), W'(0));
    end
    nxt(); @(negedge clk);
    chk("t3_imem_served", W'(imem_hready_s), W'(1));
    drain("t3_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
